// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/JAL/JALR resolver with a registered, valid/ready result
// and a short wrong-path squash window after each delivered redirect.
module branch_resolve_unit #(
  parameter int XLEN          = 32,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic            i_is_branch,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic            o_taken,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_link_data,
  output logic            o_misalign,
  output logic            o_illegal,
  output logic            o_dbg_state
);

  localparam int CW = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;
  localparam logic [CW-1:0] SQ = CW'(SQUASH_CYCLES);

  typedef enum logic {ST_RUN = 1'b0, ST_SQUASH = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_out_valid, w_ov_nxt, w_load;
  logic            r_taken, r_redirect, r_misalign, r_illegal;
  logic [XLEN-1:0] r_target, r_link;

  logic            w_multi, w_eq, w_lt_s, w_lt_u, w_cond, w_bad_f3;
  logic            w_illegal, w_taken, w_jalr_only, w_misalign, w_redirect;
  logic [XLEN-1:0] w_pc_imm, w_jalr_sum, w_target, w_link;
  logic            w_accept, w_deliver;

  // Handshake: a beat moves on any edge where valid and ready are both high;
  // in_ready ignores in_valid, and the output holds while out_valid & ~out_ready.
  assign o_in_ready = ~r_out_valid | i_out_ready | (r_state == ST_SQUASH);
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_deliver  = r_out_valid & i_out_ready;

  assign w_multi = (i_is_branch & i_is_jal) | (i_is_branch & i_is_jalr) | (i_is_jal & i_is_jalr);
  assign w_eq    = (i_rs1_data == i_rs2_data);
  assign w_lt_s  = ($signed(i_rs1_data) < $signed(i_rs2_data));
  assign w_lt_u  = (i_rs1_data < i_rs2_data);

  always_comb begin
    w_cond   = 1'b0;
    w_bad_f3 = 1'b0;
    case (i_func3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = ~w_eq;
      3'b100:  w_cond = w_lt_s;
      3'b101:  w_cond = ~w_lt_s;
      3'b110:  w_cond = w_lt_u;
      3'b111:  w_cond = ~w_lt_u;
      default: w_bad_f3 = 1'b1;
    endcase
  end

  assign w_illegal   = w_multi | (i_is_branch & w_bad_f3) | (i_is_jalr & (i_func3 != 3'b000));
  assign w_taken     = ~w_illegal & (i_is_jal | i_is_jalr | (i_is_branch & w_cond));
  assign w_jalr_only = i_is_jalr & ~i_is_branch & ~i_is_jal;
  assign w_pc_imm    = i_pc + i_imm;
  assign w_jalr_sum  = i_rs1_data + i_imm;
  assign w_target    = w_jalr_only ? (w_jalr_sum & ~XLEN'(1)) : w_pc_imm;
  assign w_link      = ((i_is_jal | i_is_jalr) & ~w_multi) ? (i_pc + XLEN'(4)) : '0;
  assign w_misalign  = w_taken & (w_target[1:0] != 2'b00);
  assign w_redirect  = w_taken & ~w_misalign;

  // A beat accepted on the redirect-delivery edge is already wrong-path.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ov_nxt    = r_out_valid;
    w_load      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_deliver && r_redirect && (SQUASH_CYCLES > 0)) begin
          w_ov_nxt    = 1'b0;
          w_cnt_nxt   = w_accept ? (SQ - CW'(1)) : SQ;
          w_state_nxt = (w_cnt_nxt == '0) ? ST_RUN : ST_SQUASH;
        end else if (w_accept) begin
          w_ov_nxt = 1'b1;
          w_load   = 1'b1;
        end else if (w_deliver) begin
          w_ov_nxt = 1'b0;
        end
      end
      ST_SQUASH: begin
        w_ov_nxt = 1'b0;
        if (w_accept) begin
          w_cnt_nxt   = r_cnt - CW'(1);
          w_state_nxt = (w_cnt_nxt == '0) ? ST_RUN : ST_SQUASH;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_taken     <= 1'b0;
      r_redirect  <= 1'b0;
      r_misalign  <= 1'b0;
      r_illegal   <= 1'b0;
      r_target    <= '0;
      r_link      <= '0;
    end else if (i_flush) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_ov_nxt;
      if (w_load) begin
        r_taken    <= w_taken;
        r_redirect <= w_redirect;
        r_misalign <= w_misalign;
        r_illegal  <= w_illegal;
        r_target   <= w_target;
        r_link     <= w_link;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_taken     = r_taken;
  assign o_redirect  = r_redirect;
  assign o_target    = r_target;
  assign o_link_data = r_link;
  assign o_misalign  = r_misalign;
  assign o_illegal   = r_illegal;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random
// traffic, with a reference model feeding an expected-result queue.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        i_reset_n, i_in_valid, o_in_ready;
  logic        i_is_branch, i_is_jal, i_is_jalr;
  logic [2:0]  i_func3;
  logic [31:0] i_pc, i_imm, i_rs1_data, i_rs2_data;
  logic        i_flush, o_out_valid, i_out_ready;
  logic        o_taken, o_redirect, o_misalign, o_illegal, o_dbg_state;
  logic [31:0] o_target, o_link_data;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .SQUASH_CYCLES(2)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_is_branch(i_is_branch), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
    .i_func3(i_func3), .i_pc(i_pc), .i_imm(i_imm), .i_rs1_data(i_rs1_data),
    .i_rs2_data(i_rs2_data), .i_flush(i_flush), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_taken(o_taken), .o_redirect(o_redirect),
    .o_target(o_target), .o_link_data(o_link_data), .o_misalign(o_misalign),
    .o_illegal(o_illegal), .o_dbg_state(o_dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Result packing: {taken, redirect, target[31:0], link[31:0], misalign, illegal}
  function automatic logic [67:0] resolve(input logic b, input logic j, input logic r,
                                          input logic [2:0] f3, input logic [31:0] pc,
                                          input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] rs2);
    logic cond, ill, tk, mis;
    logic [31:0] tgt, lnk;
    int nops;
    nops = int'(b) + int'(j) + int'(r);
    case (f3)
      3'd0:    cond = (rs1 == rs2);
      3'd1:    cond = (rs1 != rs2);
      3'd4:    cond = ($signed(rs1) < $signed(rs2));
      3'd5:    cond = ($signed(rs1) >= $signed(rs2));
      3'd6:    cond = (rs1 < rs2);
      3'd7:    cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
    ill = (nops > 1) || (b && (f3 == 3'd2 || f3 == 3'd3)) || (r && f3 != 3'd0);
    tk  = !ill && (j || r || (b && cond));
    tgt = (nops == 1 && r) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    lnk = (nops == 1 && (j || r)) ? (pc + 32'd4) : 32'd0;
    mis = tk && (tgt[1:0] != 2'b00);
    return {tk, tk && !mis, tgt, lnk, mis, ill};
  endfunction

  // Reference model of acceptance, result occupancy and squash window.
  logic        m_ov = 1'b0;
  int          m_cnt = 0;
  logic        m_rdy, m_acc, m_del;
  logic [67:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic        rnd_bp = 1'b0;

  always @(posedge clk) begin
    m_rdy = !m_ov || i_out_ready || (m_cnt > 0);
    m_acc = i_in_valid && m_rdy;
    m_del = m_ov && i_out_ready;
    if (!i_reset_n || i_flush) begin
      m_ov  = 1'b0;
      m_cnt = 0;
      exp_q.delete();
    end else if (m_cnt > 0) begin
      if (m_acc) m_cnt--;
    end else if (m_del && exp_q.size() > 0 && exp_q[0][66]) begin
      void'(exp_q.pop_front());
      m_ov  = 1'b0;
      m_cnt = m_acc ? 1 : 2;
    end else begin
      if (m_del) begin
        void'(exp_q.pop_front());
        m_ov = 1'b0;
      end
      if (m_acc) begin
        exp_q.push_back(resolve(i_is_branch, i_is_jal, i_is_jalr, i_func3,
                                i_pc, i_imm, i_rs1_data, i_rs2_data));
        m_ov = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && i_reset_n) begin
      check("in_ready", o_in_ready, (!m_ov || i_out_ready || m_cnt > 0));
      check("out_valid", o_out_valid, m_ov);
      check("state", o_dbg_state, (m_cnt > 0));
      if (o_out_valid && exp_q.size() > 0)
        check("result", {o_taken, o_redirect, o_target, o_link_data, o_misalign, o_illegal}, exp_q[0]);
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      i_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic b, input logic j, input logic r, input logic [2:0] f3,
                      input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] rs1, input logic [31:0] rs2);
    int n;
    i_is_branch = b; i_is_jal = j; i_is_jalr = r; i_func3 = f3;
    i_pc = pc; i_imm = imm; i_rs1_data = rs1; i_rs2_data = rs2;
    i_in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("send_ready", o_in_ready, 1'b1);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_is_branch = 1'b0; i_is_jal = 1'b0; i_is_jalr = 1'b0;
  endtask

  task automatic nop();
    send(1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom);
  endtask

  logic        rb, rj, rr;
  logic [2:0]  rf3;
  logic [31:0] rrs1, rrs2;
  int          k;

  initial begin
    i_reset_n = 1'b0; i_in_valid = 1'b0; i_flush = 1'b0; i_out_ready = 1'b1;
    i_is_branch = 1'b0; i_is_jal = 1'b0; i_is_jalr = 1'b0; i_func3 = 3'd0;
    i_pc = '0; i_imm = '0; i_rs1_data = '0; i_rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_out_valid, 1'b0);
    check("rst_taken", o_taken, 1'b0);
    check("rst_redirect", o_redirect, 1'b0);
    check("rst_target", o_target, 32'h0);
    check("rst_link", o_link_data, 32'h0);
    check("rst_misalign", o_misalign, 1'b0);
    check("rst_illegal", o_illegal, 1'b0);
    check("rst_state", o_dbg_state, 1'b0);
    check("rst_in_ready", o_in_ready, 1'b1);
    i_reset_n = 1'b1;
    mon_en = 1'b1;

    // Signed vs unsigned compare of -1 against 1
    send(1'b1, 1'b0, 1'b0, 3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1);
    check("blt_taken", o_taken, 1'b1);
    check("blt_redirect", o_redirect, 1'b1);
    check("blt_target", o_target, 32'h120);
    nop(); nop();
    send(1'b1, 1'b0, 1'b0, 3'b110, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1);
    check("bltu_valid", o_out_valid, 1'b1);
    check("bltu_taken", o_taken, 1'b0);
    check("bltu_redirect", o_redirect, 1'b0);

    // JALR misaligned, then aligned
    send(1'b0, 1'b0, 1'b1, 3'b000, 32'h200, 32'h4, 32'h1003, 32'h0);
    check("jalr4_target", o_target, 32'h1006);
    check("jalr4_link", o_link_data, 32'h204);
    check("jalr4_misalign", o_misalign, 1'b1);
    check("jalr4_redirect", o_redirect, 1'b0);
    send(1'b0, 1'b0, 1'b1, 3'b000, 32'h200, 32'h5, 32'h1003, 32'h0);
    check("jalr5_target", o_target, 32'h1008);
    check("jalr5_misalign", o_misalign, 1'b0);
    check("jalr5_redirect", o_redirect, 1'b1);
    nop(); nop();

    // Squash window after a taken BNE
    send(1'b1, 1'b0, 1'b0, 3'b001, 32'h400, 32'h10, 32'h5, 32'h6);
    check("bne_valid", o_out_valid, 1'b1);
    nop();
    check("sq1_valid", o_out_valid, 1'b0);
    check("sq1_state", o_dbg_state, 1'b1);
    nop();
    check("sq2_valid", o_out_valid, 1'b0);
    nop();
    check("sq3_valid", o_out_valid, 1'b1);
    check("sq3_state", o_dbg_state, 1'b0);

    // Backpressure on a taken BEQ
    send(1'b1, 1'b0, 1'b0, 3'b000, 32'h300, 32'h40, 32'h7, 32'h7);
    i_out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", o_in_ready, 1'b0);
      check("bp_valid", o_out_valid, 1'b1);
      check("bp_target", o_target, 32'h340);
    end
    @(posedge clk);
    #1;
    i_out_ready = 1'b1;
    nop();
    check("bp_squash_state", o_dbg_state, 1'b1);
    check("bp_squash_valid", o_out_valid, 1'b0);
    nop();
    check("bp_run_state", o_dbg_state, 1'b0);

    // Illegal encodings
    send(1'b1, 1'b0, 1'b0, 3'b010, 32'h40, 32'h8, 32'h1, 32'h1);
    check("f3_illegal", o_illegal, 1'b1);
    check("f3_taken", o_taken, 1'b0);
    send(1'b0, 1'b1, 1'b1, 3'b000, 32'h40, 32'h8, 32'h1, 32'h1);
    check("multi_illegal", o_illegal, 1'b1);
    check("multi_taken", o_taken, 1'b0);
    check("multi_link", o_link_data, 32'h0);

    // Flush while a result is held; the concurrent input is dropped
    send(1'b1, 1'b0, 1'b0, 3'b000, 32'h500, 32'h8, 32'h1, 32'h2);
    i_out_ready = 1'b0;
    @(posedge clk);
    #1;
    i_flush = 1'b1; i_in_valid = 1'b1; i_is_jal = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0; i_in_valid = 1'b0; i_is_jal = 1'b0;
    check("flush_valid", o_out_valid, 1'b0);
    check("flush_state", o_dbg_state, 1'b0);
    i_out_ready = 1'b1;

    // Reset in the middle of a squash window
    send(1'b1, 1'b0, 1'b0, 3'b001, 32'h600, 32'h8, 32'h1, 32'h2);
    nop();
    check("pre_rst_state", o_dbg_state, 1'b1);
    i_reset_n = 1'b0;
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    check("mid_rst_valid", o_out_valid, 1'b0);
    check("mid_rst_taken", o_taken, 1'b0);
    check("mid_rst_target", o_target, 32'h0);
    check("mid_rst_state", o_dbg_state, 1'b0);
    send(1'b1, 1'b0, 1'b0, 3'b111, 32'h700, 32'hC, 32'h5, 32'h5);
    check("post_rst_valid", o_out_valid, 1'b1);
    check("post_rst_taken", o_taken, 1'b1);
    check("post_rst_target", o_target, 32'h70C);

    // Random traffic with random downstream stalls
    rnd_bp = 1'b1;
    repeat (80) begin
      k = $urandom_range(0, 5);
      rb = (k <= 1); rj = (k == 2); rr = (k == 3);
      if (k == 5) begin
        rb = 1'($urandom_range(0, 1)); rj = 1'b1; rr = !rb || ($urandom_range(0, 1) != 0);
      end
      rf3 = 3'($urandom_range(0, 7));
      if (k == 3 && $urandom_range(0, 3) != 0) rf3 = 3'd0;
      rrs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
      rrs2 = ($urandom_range(0, 2) == 0) ? rrs1 : $urandom;
      send(rb, rj, rr, rf3, $urandom & 32'hFFFF_FFFC, 32'($urandom_range(0, 255)) - 32'd128,
           rrs1, rrs2);
    end
    rnd_bp = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    i_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_valid", o_out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
